ifetch_buffer: RTL and testbench

Instruction prefetch queue sitting between the program memory and the IF/ID pipeline register. It owns the fetch PC, and each cycle it fetches one word from the combinational-read program memory into a small FIFO. It presents the oldest entry (instruction plus PC+4) to decode with a valid/stall handshake. A branch redirect from the EX/MEM stage flushes the queue and restarts fetch at the target.

---
 rtl/ifetch_buffer.sv | 101 ++++++++++
 tb/tb_ifetch_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction prefetch queue between the combinational-read
// program memory and the IF/ID register. Owns the fetch PC, fetches one word
// per cycle into a DEPTH-entry FIFO and presents the oldest entry to decode.
// A branch redirect empties the queue and restarts fetch at the target.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_data,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Control state (reset) and queue storage (never reset, contents don't-care)
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pcp4_q  [DEPTH];

  logic [31:0]   pc_plus4;
  logic          pop;
  logic          push;

  assign pc_plus4  = pc_q + 32'd4;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & ~stall;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push      = ~redirect & ((cnt_q < FULL_CNT) | pop);

  // Next-state for PC, pointers and count; redirect overrides everything.
  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect) begin
      // A pop in this cycle is still consumed by decode; the queue is emptied anyway.
      pc_d  = redirect_pc & ~32'h3;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + PW'(1);
        pc_d = pc_plus4;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Queue storage write: fetched word plus the address following it.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_q[wr_q] <= imem_data;
      pcp4_q[wr_q]  <= pc_plus4;
    end
  end

  // Head presentation is decoded purely from registers; NOP/zero when empty.
  assign imem_addr    = pc_q;
  assign out_instr    = out_valid ? instr_q[rd_q] : 32'h0;
  assign out_pc_plus4 = out_valid ? pcp4_q[rd_q]  : 32'h0;
  assign occupancy    = cnt_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CW       = $clog2(DEPTH+1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          stall = 1'b0;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
    .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Program memory: word k at address 4k holds k+100.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {instr, pc+4} and a fetch PC.
  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;
  bit          model_ok = 1'b0;

  always @(posedge CLK) begin
    bit mpop, mpush;
    if (RST) begin
      mq.delete();
      mpc      = RESET_PC;
      model_ok = 1'b1;
    end else if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      mpop  = (mq.size() > 0) && !stall;
      mpush = (mq.size() < DEPTH) || mpop;
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        mq.push_back({mem(mpc), mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    if (model_ok) begin
      chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("m_instr", out_instr, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      chk("m_pcp4", out_pc_plus4, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
      chk("m_occ", 32'(occupancy), 32'(mq.size()));
      chk("m_addr", imem_addr, mpc);
    end
  end

  task automatic step(input logic r, input logic rd, input logic [31:0] rp, input logic s);
    RST = r; redirect = rd; redirect_pc = rp; stall = s;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pcp4", out_pc_plus4, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);

    // Streaming after reset
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0);
      chk("str_valid", {31'b0, out_valid}, 32'h1);
      chk("str_instr", out_instr, 32'(100 + k));
      chk("str_pcp4", out_pc_plus4, 32'(4 * (k + 1)));
      chk("str_occ", 32'(occupancy), 32'h1);
    end

    // Fill to full from an empty queue
    step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1);
      chk("fill_instr", out_instr, 32'd100);
      chk("fill_occ", 32'(occupancy), 32'((k + 1 < DEPTH) ? k + 1 : DEPTH));
    end
    chk("fill_addr", imem_addr, 32'h10);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0);
      chk("rel_instr", out_instr, 32'(101 + k));
      chk("rel_occ", 32'(occupancy), 32'(DEPTH));
    end

    // Redirect while streaming
    step(0, 1, 32'h0000_0043, 0);
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0);
    chk("redir_instr", out_instr, 32'd116);
    chk("redir_pcp4", out_pc_plus4, 32'h44);
    step(0, 0, 0, 0);
    chk("redir_instr2", out_instr, 32'd117);

    // Redirect together with stall while full
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
    chk("full_occ", 32'(occupancy), 32'(DEPTH));
    step(0, 1, 32'h0000_0100, 1);
    chk("rs_occ", 32'(occupancy), 32'h0);
    chk("rs_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0);
    chk("rs_instr", out_instr, 32'd164);
    chk("rs_pcp4", out_pc_plus4, 32'h104);

    // PC wrap
    step(0, 1, 32'hFFFF_FFF8, 0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    chk("wrap_pcp4_0", out_pc_plus4, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pcp4_1", out_pc_plus4, 32'h0000_0000);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    step(0, 0, 0, 0);
    chk("wrap_pcp4_2", out_pc_plus4, 32'h0000_0004);

    // Reset mid-operation with three entries held
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("mid_occ3", 32'(occupancy), 32'h3);
    step(1, 0, 0, 0);
    chk("mid_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_occ", 32'(occupancy), 32'h0);
    chk("mid_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      chk("mid_instr", out_instr, 32'(100 + k));
      chk("mid_pcp4", out_pc_plus4, 32'(4 * (k + 1)));
    end

    // Randomized traffic checked by the model each cycle
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0),
           $urandom,
           ($urandom_range(0, 99) < 55));
    end
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
